// File: rtl/reg_bank_pkg.sv
// Shared types and defaults for the register-bank write arbiter.
package reg_bank_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  localparam int unsigned NREQ_DEF  = 4;
  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned NREG_DEF  = 4;
  localparam int unsigned AW_DEF    = 2;

  // Width of a requester index; never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_bank_arbiter_rr_pick.sv
// Round-robin selector: lowest requester at or above ptr, else lowest overall.
module rr_pick
  import reg_bank_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            valid_c,
  output logic [IW-1:0]   idx_c
);

  // Descending scans so the lowest qualifying index is written last.
  always_comb begin
    valid_c = |req;
    idx_c   = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (req[i]) idx_c = IW'(i);
    end
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (req[i] && (i >= int'(ptr))) idx_c = IW'(i);
    end
  end

endmodule

// File: rtl/register.sv
// Loadable register with asynchronous active-low clear.
module register #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q <= '0;
    else if (load) q <= d;
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin write sequencer for a small bank of shared configuration registers.
module reg_bank_arbiter
  import reg_bank_pkg::*;
#(
  parameter int unsigned NREQ  = NREQ_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned NREG  = NREG_DEF,
  parameter int unsigned AW    = AW_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       ack,
  output logic                  err,
  output logic                  busy,
  input  logic [AW-1:0]         rd_addr,
  output logic [WIDTH-1:0]      rd_data,
  output logic [NREG*WIDTH-1:0] reg_q
);

  localparam int unsigned IW = idx_width(NREQ);

  state_t            state, next_state;
  logic [IW-1:0]     ptr;
  logic [IW-1:0]     gnt_idx;
  logic [AW-1:0]     gnt_addr;
  logic [WIDTH-1:0]  gnt_data;
  logic              pick_valid;
  logic [IW-1:0]     pick_idx;
  logic [AW-1:0]     sel_addr;
  logic [WIDTH-1:0]  sel_data;
  logic              capture_c;
  logic              in_range_c;
  logic [NREG-1:0]   load_c;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req     (req),
    .ptr     (ptr),
    .valid_c (pick_valid),
    .idx_c   (pick_idx)
  );

  // Winner's address/data mux.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (pick_idx == IW'(i)) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign in_range_c = (int'(gnt_addr) < int'(NREG));

  // Next state and per-entry load strobes.
  always_comb begin
    next_state = state;
    capture_c  = 1'b0;
    load_c     = '0;
    unique case (state)
      S_IDLE: begin
        if (pick_valid) begin
          capture_c  = 1'b1;
          next_state = S_LOAD;
        end
      end
      S_LOAD: begin
        for (int e = 0; e < int'(NREG); e++) begin
          load_c[e] = in_range_c && (gnt_addr == AW'(e));
        end
        next_state = S_ACK;
      end
      S_ACK:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      ptr      <= '0;
      gnt_idx  <= '0;
      gnt_addr <= '0;
      gnt_data <= '0;
      ack      <= '0;
      err      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state != S_IDLE);
      ack   <= (next_state == S_ACK) ? (NREQ'(1) << gnt_idx) : '0;
      err   <= (next_state == S_ACK) && !in_range_c;
      if (capture_c) begin
        gnt_idx  <= pick_idx;
        gnt_addr <= sel_addr;
        gnt_data <= sel_data;
      end
      if (state == S_ACK) begin
        ptr <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
      end
    end
  end

  for (genvar e = 0; e < NREG; e++) begin : g_entry
    register #(.WIDTH(WIDTH)) u_reg (
      .clk   (clk),
      .reset (reset),
      .load  (load_c[e]),
      .d     (gnt_data),
      .q     (reg_q[e*WIDTH +: WIDTH])
    );
  end

  // Read port; unmapped addresses return zero.
  always_comb begin
    rd_data = '0;
    for (int e = 0; e < int'(NREG); e++) begin
      if (rd_addr == AW'(e)) rd_data = reg_q[e*WIDTH +: WIDTH];
    end
  end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed and randomized bench for reg_bank_arbiter against a transaction-level model.
module tb_reg_bank_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int NREG  = 3;
  localparam int AW    = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       ack;
  logic                  err;
  logic                  busy;
  logic [AW-1:0]         rd_addr;
  logic [WIDTH-1:0]      rd_data;
  logic [NREG*WIDTH-1:0] reg_q;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int m_ptr;
  logic [WIDTH-1:0] m_bank [NREG];
  logic [AW-1:0]    m_addr [NREQ];
  logic [WIDTH-1:0] m_data [NREQ];

  reg_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .NREG(NREG), .AW(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .ack      (ack),
    .err      (err),
    .busy     (busy),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .reg_q    (reg_q)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round-robin choice: first requester found walking upward from ptr with wrap.
  function automatic int model_pick(input logic [NREQ-1:0] r);
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (m_ptr + k) % NREQ;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_clear();
    m_ptr = 0;
    for (int e = 0; e < NREG; e++) m_bank[e] = '0;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    m_addr[i] = a;
    m_data[i] = d;
    req_addr[i*AW +: AW] = a;
    req_data[i*WIDTH +: WIDTH] = d;
    req[i] = 1'b1;
  endtask

  task automatic check_bank();
    for (int e = 0; e < NREG; e++) check("bank", 32'(reg_q[e*WIDTH +: WIDTH]), 32'(m_bank[e]));
    for (int a = 0; a < (1 << AW); a++) begin
      rd_addr = AW'(a);
      #1;
      check("rd_data", 32'(rd_data), (a < NREG) ? 32'(m_bank[a]) : 32'd0);
    end
  endtask

  // Wait for the next ack, compare with the model, then retire the write in the model.
  task automatic serve(output int idx);
    int p;
    int n;
    logic [NREQ-1:0] exp_ack;
    p = model_pick(req);
    exp_ack = (p < 0) ? '0 : (NREQ'(1) << p);
    n = 0;
    do begin
      tick();
      n++;
    end while (ack == '0 && n < 12);
    check("ack", 32'(ack), 32'(exp_ack));
    idx = p;
    if (p >= 0) begin
      check("err", 32'(err), 32'(int'(m_addr[p]) >= NREG));
      if (int'(m_addr[p]) < NREG) m_bank[m_addr[p]] = m_data[p];
      m_ptr = (p + 1) % NREQ;
      req[p] = 1'b0;
      check_bank();
    end
  endtask

  initial begin
    int idx;
    int prev;
    int g3;
    int grants;
    int last;
    bit pend3;
    bit fair_ok;

    reset = 1'b0;
    req = '0;
    req_addr = '0;
    req_data = '0;
    rd_addr = '0;
    model_clear();

    // Reset then idle.
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check_bank();

    // Contention: all four hold req, each writes its own index to addr 0.
    for (int i = 0; i < NREQ; i++) set_req(i, 2'd0, 8'(i));
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      serve(idx);
      check("cont_order", 32'(idx), 32'(k % NREQ));
      check("cont_entry0", 32'(reg_q[0 +: WIDTH]), 32'(k % NREQ));
      if (k > 0) check("cont_gap", 32'(cyc - prev), 32'd3);
      prev = cyc;
      if (k < 4) set_req(idx, 2'd0, 8'(idx));
    end
    req = '0;
    repeat (3) tick();

    // Single write with cycle-exact timing and read/write collision.
    set_req(2, 2'd1, 8'hA5);
    tick();
    check("sw_busy_e0", 32'(busy), 32'd1);
    check("sw_ack_e0", 32'(ack), 32'd0);
    rd_addr = 2'd1;
    #1;
    check("sw_rd_old", 32'(rd_data), 32'(m_bank[1]));
    tick();
    check("sw_ack_e1", 32'(ack), 32'b0100);
    check("sw_busy_e1", 32'(busy), 32'd1);
    check("sw_err_e1", 32'(err), 32'd0);
    m_bank[1] = 8'hA5;
    m_ptr = 3;
    req[2] = 1'b0;
    check_bank();
    tick();
    check("sw_busy_e2", 32'(busy), 32'd0);
    check("sw_ack_e2", 32'(ack), 32'd0);
    repeat (2) tick();

    // Out-of-range address leaves the bank untouched.
    set_req(1, 2'd3, 8'hFF);
    serve(idx);
    check("oor_idx", 32'(idx), 32'd1);
    repeat (2) tick();

    // Reset during LOAD aborts the write; held request completes after release.
    set_req(2, 2'd2, 8'h3C);
    tick();
    check("mid_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    model_clear();
    check("mid_busy_rst", 32'(busy), 32'd0);
    check("mid_ack_rst", 32'(ack), 32'd0);
    check_bank();
    repeat (2) tick();
    check("mid_ack_hold", 32'(ack), 32'd0);
    check("mid_entry2", 32'(reg_q[2*WIDTH +: WIDTH]), 32'd0);
    reset = 1'b1;
    serve(idx);
    check("mid_resume", 32'(idx), 32'd2);
    repeat (2) tick();

    // Fairness: req[0] permanent, req[3] raised once.
    set_req(0, 2'd1, 8'h11);
    set_req(3, 2'd2, 8'h33);
    pend3 = 1'b1;
    grants = 0;
    g3 = 0;
    last = -1;
    for (int g = 0; g < 6 && pend3; g++) begin
      serve(idx);
      grants++;
      if (idx == 3) begin
        pend3 = 1'b0;
        g3 = grants;
      end
      check("fair_no_double0", 32'(idx == 0 && last == 0), 32'd0);
      last = idx;
      if (idx == 0) set_req(0, 2'd1, 8'(8'h11 + 8'(grants)));
    end
    fair_ok = (g3 >= 1 && g3 <= 2);
    check("fair_latency", 32'(fair_ok), 32'd1);
    req[0] = 1'b0;
    repeat (3) tick();

    // Randomized traffic with requesters joining while others wait.
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && $urandom_range(0, 2) == 0)
          set_req(i, AW'($urandom_range(0, (1 << AW) - 1)), WIDTH'($urandom));
      end
      if (req != '0) serve(idx);
      else tick();
    end
    for (int d = 0; d < 2 * NREQ && req != '0; d++) serve(idx);
    repeat (3) tick();
    check("end_busy", 32'(busy), 32'd0);
    check("end_ack", 32'(ack), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
